aemb_div: RTL and testbench

//  Iterative radix-2 integer divider serving the idiv/idivu path of the AEMB core.

---
 rtl/aemb_div.sv | 134 +++++++++++++
 tb/tb_aemb_div.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/aemb_div.sv
// Iterative radix-2 restoring divider for the AEMB idiv/idivu path (quotient = reg_opb / reg_opa).
// Define AEMB_DIV_REM_EN to expose the signed remainder on dat_rem.
module aemb_div #(
    parameter int DIV = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sys_ena,
    input  logic        div_start,
    input  logic        div_sign,
    input  logic [31:0] reg_opa,
    input  logic [31:0] reg_opb,
    output logic [31:0] dat_div,
    output logic        div_busy,
    output logic        div_done,
    output logic        div_dbz
`ifdef AEMB_DIV_REM_EN
    ,
    output logic [31:0] dat_rem
`endif
);

    localparam bit HAS_DIV = (DIV != 0);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        res_neg;
    logic        rem_neg;
    logic        dbz_pend;
    logic [31:0] opa_mag;
    logic [31:0] opb_mag;
    logic [32:0] step_sh;
    logic [32:0] step_diff;

    assign div_busy = (state == CALC) || (state == FIX);
    assign div_done = (state == DONE);

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor; a borrow means the bit is 0.
    always_comb begin
        opa_mag   = (div_sign && reg_opa[31]) ? (~reg_opa + 32'd1) : reg_opa;
        opb_mag   = (div_sign && reg_opb[31]) ? (~reg_opb + 32'd1) : reg_opb;
        step_sh   = {rem, quo[31]};
        step_diff = step_sh - {1'b0, dvs};
    end

    // A zero divisor still passes through FIX so the flag and forced-zero
    // result are loaded on the same path as a normal result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (div_start) state_nxt = HAS_DIV ? ((reg_opa == 32'd0) ? FIX : CALC) : DONE;
            end
            DONE: begin
                if (div_start) state_nxt = HAS_DIV ? ((reg_opa == 32'd0) ? FIX : CALC) : DONE;
                else           state_nxt = IDLE;
            end
            CALC: begin
                if (cnt == 6'd31) state_nxt = FIX;
            end
            FIX: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            dvs      <= 32'd0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            dbz_pend <= 1'b0;
            dat_div  <= 32'd0;
            div_dbz  <= 1'b0;
`ifdef AEMB_DIV_REM_EN
            dat_rem  <= 32'd0;
`endif
        end else if (sys_ena) begin
            state <= state_nxt;
            case (state)
                IDLE, DONE: begin
                    if (div_start) begin
                        div_dbz <= 1'b0;
                        if (HAS_DIV) begin
                            quo      <= opb_mag;
                            dvs      <= opa_mag;
                            rem      <= 32'd0;
                            cnt      <= 6'd0;
                            res_neg  <= (reg_opa[31] ^ reg_opb[31]) & div_sign;
                            rem_neg  <= reg_opb[31] & div_sign;
                            dbz_pend <= (reg_opa == 32'd0);
                        end
                    end
                end
                CALC: begin
                    quo <= {quo[30:0], ~step_diff[32]};
                    rem <= step_diff[32] ? step_sh[31:0] : step_diff[31:0];
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    if (dbz_pend) begin
                        dat_div <= 32'd0;
                        div_dbz <= 1'b1;
`ifdef AEMB_DIV_REM_EN
                        dat_rem <= 32'd0;
`endif
                    end else begin
                        dat_div <= res_neg ? (~quo + 32'd1) : quo;
`ifdef AEMB_DIV_REM_EN
                        dat_rem <= rem_neg ? (~rem + 32'd1) : rem;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aemb_div.sv
// Directed self-checking bench for aemb_div: latency, signed/unsigned results,
// divide-by-zero, overflow, stall/ignore and mid-operation reset.
module tb_aemb_div;

    logic        sys_clk;
    logic        sys_rst;
    logic        sys_ena;
    logic        div_start;
    logic        div_sign;
    logic [31:0] reg_opa;
    logic [31:0] reg_opb;
    logic [31:0] dat_div;
    logic        div_busy;
    logic        div_done;
    logic        div_dbz;
`ifdef AEMB_DIV_REM_EN
    logic [31:0] dat_rem;
`endif

    int total = 0;
    int bad   = 0;

    int doneEdge;
    int busyCnt;
    logic dbzAtStart;

    aemb_div #(.DIV(1)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .sys_ena   (sys_ena),
        .div_start (div_start),
        .div_sign  (div_sign),
        .reg_opa   (reg_opa),
        .reg_opb   (reg_opb),
        .dat_div   (dat_div),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .div_dbz   (div_dbz)
`ifdef AEMB_DIV_REM_EN
        ,
        .dat_rem   (dat_rem)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic waitEdge();
        @(posedge sys_clk);
        #1;
    endtask

    // Start an operation on edge 1 and count edges until div_done is seen.
    task automatic applyStimulus(input logic [31:0] opb, input logic [31:0] opa, input logic sgn,
                                 output int dEdge, output int bCnt, output logic dbz1);
        int edgeNum;
        reg_opb   = opb;
        reg_opa   = opa;
        div_sign  = sgn;
        div_start = 1'b1;
        waitEdge();
        div_start = 1'b0;
        edgeNum   = 1;
        bCnt      = int'(div_busy);
        dbz1      = div_dbz;
        dEdge     = div_done ? 1 : 0;
        while (!div_done && edgeNum < 100) begin
            waitEdge();
            edgeNum++;
            bCnt += int'(div_busy);
            if (div_done) dEdge = edgeNum;
        end
    endtask

    initial begin
        sys_rst   = 1'b0;
        sys_ena   = 1'b1;
        div_start = 1'b0;
        div_sign  = 1'b0;
        reg_opa   = 32'd0;
        reg_opb   = 32'd0;
        waitEdge();
        waitEdge();
        checkOutput("rst_div",  dat_div, 32'd0);
        checkOutput("rst_busy", 32'(div_busy), 32'd0);
        checkOutput("rst_done", 32'(div_done), 32'd0);
        checkOutput("rst_dbz",  32'(div_dbz), 32'd0);
        sys_rst = 1'b1;
        waitEdge();

        // unsigned 100/7
        applyStimulus(32'd100, 32'd7, 1'b0, doneEdge, busyCnt, dbzAtStart);
        checkOutput("t1_edge", doneEdge, 34);
        checkOutput("t1_busy", busyCnt, 33);
        checkOutput("t1_div",  dat_div, 32'd14);
        checkOutput("t1_dbz",  32'(div_dbz), 32'd0);
        checkOutput("t1_busy_at_done", 32'(div_busy), 32'd0);
`ifdef AEMB_DIV_REM_EN
        checkOutput("t1_rem", dat_rem, 32'd2);
`endif
        waitEdge();
        checkOutput("t1_pulse", 32'(div_done), 32'd0);

        // signed; second start issued back-to-back from DONE
        applyStimulus(32'hFFFFFF9C, 32'd7, 1'b1, doneEdge, busyCnt, dbzAtStart);
        checkOutput("t2a_div", dat_div, 32'hFFFFFFF2);
`ifdef AEMB_DIV_REM_EN
        checkOutput("t2a_rem", dat_rem, 32'hFFFFFFFE);
`endif
        applyStimulus(32'd100, 32'hFFFFFFF9, 1'b1, doneEdge, busyCnt, dbzAtStart);
        checkOutput("t2b_edge", doneEdge, 34);
        checkOutput("t2b_div",  dat_div, 32'hFFFFFFF2);
`ifdef AEMB_DIV_REM_EN
        checkOutput("t2b_rem", dat_rem, 32'd2);
`endif
        applyStimulus(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, doneEdge, busyCnt, dbzAtStart);
        checkOutput("t2c_div", dat_div, 32'd14);
        waitEdge();

        // divide by zero
        applyStimulus(32'd5, 32'd0, 1'b0, doneEdge, busyCnt, dbzAtStart);
        checkOutput("t3u_edge", doneEdge, 2);
        checkOutput("t3u_div",  dat_div, 32'd0);
        checkOutput("t3u_dbz",  32'(div_dbz), 32'd1);
        waitEdge();
        applyStimulus(32'd5, 32'd0, 1'b1, doneEdge, busyCnt, dbzAtStart);
        checkOutput("t3s_edge", doneEdge, 2);
        checkOutput("t3s_div",  dat_div, 32'd0);
        checkOutput("t3s_dbz",  32'(div_dbz), 32'd1);
        applyStimulus(32'd20, 32'd4, 1'b0, doneEdge, busyCnt, dbzAtStart);
        checkOutput("t3_dbz_clr_start", 32'(dbzAtStart), 32'd0);
        checkOutput("t3_next_div", dat_div, 32'd5);
        checkOutput("t3_next_dbz", 32'(div_dbz), 32'd0);
        waitEdge();

        // overflow and unsigned extremes
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, doneEdge, busyCnt, dbzAtStart);
        checkOutput("t4_ovf_div", dat_div, 32'h80000000);
        checkOutput("t4_ovf_dbz", 32'(div_dbz), 32'd0);
        applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, doneEdge, busyCnt, dbzAtStart);
        checkOutput("t4_umax_div", dat_div, 32'hFFFFFFFF);
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b0, doneEdge, busyCnt, dbzAtStart);
        checkOutput("t4_usmall_div", dat_div, 32'd0);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, doneEdge, busyCnt, dbzAtStart);
        checkOutput("t4_ubig_div", dat_div, 32'd1);
        waitEdge();

        // stall mid-CALC and an ignored start while busy
        begin
            int edgeNum;
            int stallDone;
            reg_opb   = 32'd100;
            reg_opa   = 32'd7;
            div_sign  = 1'b0;
            div_start = 1'b1;
            waitEdge();
            div_start = 1'b0;
            edgeNum   = 1;
            for (int i = 0; i < 8; i++) begin
                waitEdge();
                edgeNum++;
            end
            sys_ena = 1'b0;
            for (int i = 0; i < 5; i++) begin
                waitEdge();
                edgeNum++;
            end
            checkOutput("t5_stall_busy", 32'(div_busy), 32'd1);
            sys_ena   = 1'b1;
            reg_opb   = 32'd1000;
            reg_opa   = 32'd3;
            div_sign  = 1'b1;
            div_start = 1'b1;
            waitEdge();
            edgeNum++;
            div_start = 1'b0;
            stallDone = 0;
            while (!div_done && edgeNum < 120) begin
                waitEdge();
                edgeNum++;
                if (div_done) stallDone = edgeNum;
            end
            checkOutput("t5_edge", stallDone, 39);
            checkOutput("t5_div",  dat_div, 32'd14);
            sys_ena = 1'b0;
            waitEdge();
            waitEdge();
            checkOutput("t5_done_held", 32'(div_done), 32'd1);
            sys_ena = 1'b1;
            waitEdge();
            checkOutput("t5_done_drop", 32'(div_done), 32'd0);
        end

        // asynchronous reset at CALC step 10
        reg_opb   = 32'd100;
        reg_opa   = 32'd7;
        div_sign  = 1'b0;
        div_start = 1'b1;
        waitEdge();
        div_start = 1'b0;
        for (int i = 0; i < 10; i++) waitEdge();
        checkOutput("t6_pre_busy", 32'(div_busy), 32'd1);
        sys_rst = 1'b0;
        #1;
        checkOutput("t6_rst_div",  dat_div, 32'd0);
        checkOutput("t6_rst_busy", 32'(div_busy), 32'd0);
        checkOutput("t6_rst_done", 32'(div_done), 32'd0);
        waitEdge();
        sys_rst = 1'b1;
        waitEdge();
        checkOutput("t6_no_done", 32'(div_done), 32'd0);
        applyStimulus(32'd100, 32'd7, 1'b0, doneEdge, busyCnt, dbzAtStart);
        checkOutput("t6_edge", doneEdge, 34);
        checkOutput("t6_div",  dat_div, 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
